// File: rtl/st_pipeline_fifo.sv
// Parametrised Avalon-ST pipeline FIFO with fill level and input-side framing checks.
// Define ST_PIPE_STATS_EN to add packet_count / error_count statistics outputs.
module st_pipeline_fifo #(
  parameter int DATA_WIDTH    = 32,
  parameter int EMPTY_WIDTH   = 2,
  parameter int CHANNEL_WIDTH = 1,
  parameter int DEPTH         = 4
) (
  input  logic                         clk_clk,
  input  logic                         reset_reset,
  output logic                         sink0_ready,
  input  logic                         sink0_valid,
  input  logic                         sink0_startofpacket,
  input  logic                         sink0_endofpacket,
  input  logic [DATA_WIDTH-1:0]        sink0_data,
  input  logic [EMPTY_WIDTH-1:0]       sink0_empty,
  input  logic [CHANNEL_WIDTH-1:0]     sink0_channel,
  input  logic                         source0_ready,
  output logic                         source0_valid,
  output logic                         source0_startofpacket,
  output logic                         source0_endofpacket,
  output logic [DATA_WIDTH-1:0]        source0_data,
  output logic [EMPTY_WIDTH-1:0]       source0_empty,
  output logic [CHANNEL_WIDTH-1:0]     source0_channel,
`ifdef ST_PIPE_STATS_EN
  output logic [31:0]                  packet_count,
  output logic [15:0]                  error_count,
`endif
  output logic [$clog2(DEPTH):0]       fill_level,
  output logic                         frame_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam int WW = DATA_WIDTH + EMPTY_WIDTH + CHANNEL_WIDTH + 2;
  localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
  localparam logic [FW-1:0] FILL_ZERO = {FW{1'b0}};

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_IN_PKT = 1'b1
  } frame_state_e;

  logic [WW-1:0]  mem_q [DEPTH];
  logic [WW-1:0]  mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]  fill_q, fill_d;
  logic           ready_q, ready_d;
  logic           frame_error_q, frame_error_d;
  frame_state_e   state_q, state_d;

  logic           push_s;
  logic           pop_s;
  logic           violation_s;
  logic [WW-1:0]  sink_word_s;
  logic [WW-1:0]  head_word_s;

  // ready_q is a flop, so acceptance never depends on this cycle's pop
  assign push_s      = sink0_valid & ready_q;
  assign pop_s       = (fill_q != FILL_ZERO) & source0_ready;
  assign sink_word_s = {sink0_startofpacket, sink0_endofpacket, sink0_empty,
                        sink0_channel, sink0_data};
  assign head_word_s = mem_q[rd_ptr_q];

  assign sink0_ready   = ready_q;
  assign source0_valid = (fill_q != FILL_ZERO);
  assign fill_level    = fill_q;
  assign frame_error   = frame_error_q;
  assign {source0_startofpacket, source0_endofpacket, source0_empty,
          source0_channel, source0_data} = head_word_s;

  // storage write, pointer and occupancy next-state
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = sink_word_s;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(1);
      default: fill_d = fill_q;
    endcase
    ready_d = (fill_d != FILL_FULL);
  end

  // framing checker: next state only depends on eop, the error on sop vs. state
  always_comb begin
    state_d       = state_q;
    violation_s   = 1'b0;
    frame_error_d = 1'b0;
    if (push_s) begin
      case (state_q)
        S_IDLE:   violation_s = ~sink0_startofpacket;
        S_IN_PKT: violation_s = sink0_startofpacket;
        default:  violation_s = 1'b0;
      endcase
      state_d       = sink0_endofpacket ? S_IDLE : S_IN_PKT;
      frame_error_d = violation_s;
    end else begin
      state_d       = state_q;
      frame_error_d = 1'b0;
    end
  end

  // buffer contents are not reset; they are discarded via the pointers
  always_ff @(posedge clk_clk) begin
    mem_q <= mem_d;
  end

  // control state registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      wr_ptr_q      <= {AW{1'b0}};
      rd_ptr_q      <= {AW{1'b0}};
      fill_q        <= FILL_ZERO;
      ready_q       <= 1'b0;
      frame_error_q <= 1'b0;
      state_q       <= S_IDLE;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      fill_q        <= fill_d;
      ready_q       <= ready_d;
      frame_error_q <= frame_error_d;
      state_q       <= state_d;
    end
  end

`ifdef ST_PIPE_STATS_EN
  logic [31:0] packet_count_q, packet_count_d;
  logic [15:0] error_count_q, error_count_d;

  // packets counted at the output, errors counted from the registered pulse
  always_comb begin
    packet_count_d = packet_count_q;
    error_count_d  = error_count_q;
    if (pop_s && source0_endofpacket) begin
      packet_count_d = packet_count_q + 32'd1;
    end else begin
      packet_count_d = packet_count_q;
    end
    if (frame_error_q && (error_count_q != 16'hFFFF)) begin
      error_count_d = error_count_q + 16'd1;
    end else begin
      error_count_d = error_count_q;
    end
  end

  // statistics registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      packet_count_q <= 32'd0;
      error_count_q  <= 16'd0;
    end else begin
      packet_count_q <= packet_count_d;
      error_count_q  <= error_count_d;
    end
  end

  assign packet_count = packet_count_q;
  assign error_count  = error_count_q;
`endif

endmodule

// File: tb/tb_st_pipeline_fifo.sv
// Randomised self-checking bench for st_pipeline_fifo using a queue-based reference model.
module tb_st_pipeline_fifo;

  localparam int DW = 32;
  localparam int EW = 2;
  localparam int CW = 1;
  localparam int DEPTH = 4;
  localparam int FW = $clog2(DEPTH) + 1;

  typedef struct {
    logic          sop;
    logic          eop;
    logic [EW-1:0] empty;
    logic [CW-1:0] ch;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk_clk = 1'b0;
  logic          reset_reset;
  logic          sink0_ready;
  logic          sink0_valid;
  logic          sink0_startofpacket;
  logic          sink0_endofpacket;
  logic [DW-1:0] sink0_data;
  logic [EW-1:0] sink0_empty;
  logic [CW-1:0] sink0_channel;
  logic          source0_ready;
  logic          source0_valid;
  logic          source0_startofpacket;
  logic          source0_endofpacket;
  logic [DW-1:0] source0_data;
  logic [EW-1:0] source0_empty;
  logic [CW-1:0] source0_channel;
  logic [FW-1:0] fill_level;
  logic          frame_error;
`ifdef ST_PIPE_STATS_EN
  logic [31:0]   packet_count;
  logic [15:0]   error_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // reference model state
  beat_t       m_q[$];
  logic        m_ready = 1'b0;
  logic        m_err = 1'b0;
  logic        m_in_pkt = 1'b0;
  logic [31:0] m_pkt = 32'd0;
  logic [15:0] m_errcnt = 16'd0;

  st_pipeline_fifo #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW), .DEPTH(DEPTH)) dut (
    .clk_clk(clk_clk),
    .reset_reset(reset_reset),
    .sink0_ready(sink0_ready),
    .sink0_valid(sink0_valid),
    .sink0_startofpacket(sink0_startofpacket),
    .sink0_endofpacket(sink0_endofpacket),
    .sink0_data(sink0_data),
    .sink0_empty(sink0_empty),
    .sink0_channel(sink0_channel),
    .source0_ready(source0_ready),
    .source0_valid(source0_valid),
    .source0_startofpacket(source0_startofpacket),
    .source0_endofpacket(source0_endofpacket),
    .source0_data(source0_data),
    .source0_empty(source0_empty),
    .source0_channel(source0_channel),
`ifdef ST_PIPE_STATS_EN
    .packet_count(packet_count),
    .error_count(error_count),
`endif
    .fill_level(fill_level),
    .frame_error(frame_error)
  );

  always #5 clk_clk = ~clk_clk;

  // One clock: drive inputs, advance the model over the rising edge, return at the falling edge.
  task automatic step(input logic v, input logic sop, input logic eop, input logic [DW-1:0] d,
                      input logic [EW-1:0] e, input logic [CW-1:0] c, input logic srdy,
                      input logic rst, output logic pushed);
    logic push;
    logic pop;
    logic viol;
    beat_t b;
    reset_reset         = rst;
    sink0_valid         = v;
    sink0_startofpacket = sop;
    sink0_endofpacket   = eop;
    sink0_data          = d;
    sink0_empty         = e;
    sink0_channel       = c;
    source0_ready       = srdy;
    push = v && m_ready && !rst;
    pop  = (m_q.size() != 0) && srdy && !rst;
    @(posedge clk_clk);
    if (rst) begin
      m_q.delete();
      m_ready  = 1'b0;
      m_err    = 1'b0;
      m_in_pkt = 1'b0;
      m_pkt    = 32'd0;
      m_errcnt = 16'd0;
    end else begin
      if (m_err && m_errcnt != 16'hFFFF) m_errcnt = m_errcnt + 16'd1;
      if (pop) begin
        if (m_q[0].eop) m_pkt = m_pkt + 32'd1;
        void'(m_q.pop_front());
      end
      viol = 1'b0;
      if (push) begin
        b.sop = sop; b.eop = eop; b.empty = e; b.ch = c; b.data = d;
        m_q.push_back(b);
        // a packet must open with sop, and sop may not appear inside an open packet
        if (!m_in_pkt) viol = !sop;
        else viol = sop;
        if (eop) m_in_pkt = 1'b0;
        else m_in_pkt = 1'b1;
      end
      m_err   = viol;
      m_ready = (m_q.size() < DEPTH);
    end
    @(negedge clk_clk);
    pushed = push;
  endtask

  task automatic test_reset();
    logic p;
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, p);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, p);
    tests_run++;
    if (fill_level !== 3'd0 || source0_valid !== 1'b0 || sink0_ready !== 1'b0 || frame_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: fill=%0d valid=%b ready=%b ferr=%b, required 0 0 0 0",
               fill_level, source0_valid, sink0_ready, frame_error);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, p);
    tests_run++;
    if (sink0_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_release: ready=%b, required 1", sink0_ready);
    end
  endtask

  task automatic test_single_beat();
    logic p;
    step(1'b1, 1'b1, 1'b1, 32'hA5A5_0001, 2'd2, 1'b1, 1'b1, 1'b0, p);
    tests_run++;
    if (source0_valid !== 1'b1 || source0_data !== 32'hA5A5_0001 || source0_startofpacket !== 1'b1 ||
        source0_endofpacket !== 1'b1 || source0_empty !== 2'd2 || source0_channel !== 1'b1 ||
        fill_level !== 3'd1 || frame_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_beat_out: v=%b d=%h sop=%b eop=%b e=%0d ch=%0d fill=%0d ferr=%b, required 1 a5a50001 1 1 2 1 1 0",
               source0_valid, source0_data, source0_startofpacket, source0_endofpacket,
               source0_empty, source0_channel, fill_level, frame_error);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, p);
    tests_run++;
    if (fill_level !== 3'd0 || source0_valid !== 1'b0 || frame_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_beat_drain: fill=%0d valid=%b ferr=%b, required 0 0 0",
               fill_level, source0_valid, frame_error);
    end
  endtask

  task automatic test_full();
    logic p;
    logic sent5;
    logic had;
    int k;
    logic [DW-1:0] expv [5];
    for (int i = 0; i < 5; i++) expv[i] = 32'h10 + 32'(i);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i == 0), (i == 3), expv[i], 2'(i), 1'(i), 1'b0, 1'b0, p);
      tests_run++;
      if (fill_level !== FW'(i + 1)) begin
        tests_failed++;
        $display("FAIL full_fill_%0d: fill=%0d, required %0d", i, fill_level, i + 1);
      end
    end
    tests_run++;
    if (sink0_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_ready_low: ready=%b, required 0", sink0_ready);
    end
    step(1'b1, 1'b1, 1'b1, expv[4], 2'd3, 1'b0, 1'b0, 1'b0, p);
    tests_run++;
    if (fill_level !== 3'd4 || p !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_holdoff: fill=%0d, required 4", fill_level);
    end
    k = 0;
    sent5 = 1'b0;
    for (int cyc = 0; cyc < 20 && k < 5; cyc++) begin
      had = (m_q.size() != 0);
      if (had) begin
        tests_run++;
        if (source0_valid !== 1'b1 || source0_data !== expv[k]) begin
          tests_failed++;
          $display("FAIL full_order_%0d: valid=%b data=%h, required 1 %h", k, source0_valid, source0_data, expv[k]);
        end
      end
      step(!sent5, 1'b1, 1'b1, expv[4], 2'd3, 1'b0, 1'b1, 1'b0, p);
      if (p) sent5 = 1'b1;
      if (had) k++;
    end
    tests_run++;
    if (k != 5 || fill_level !== 3'd0) begin
      tests_failed++;
      $display("FAIL full_drain_bound: drained=%0d fill=%0d, required 5 0", k, fill_level);
    end
  endtask

  task automatic test_back_to_back();
    logic p;
    logic [DW-1:0] prev;
    logic [DW-1:0] d;
    int bad;
    bad = 0;
    prev = '0;
    for (int i = 0; i < 100; i++) begin
      d = $urandom;
      step(1'b1, (i % 5 == 0), (i % 5 == 4), d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'b1, 1'b0, p);
      if (fill_level !== 3'd1 || source0_valid !== 1'b1 || source0_data !== d ||
          frame_error !== 1'b0 || source0_empty !== m_q[0].empty || source0_channel !== m_q[0].ch) begin
        bad++;
        if (bad < 4)
          $display("FAIL stream_beat_%0d: fill=%0d valid=%b data=%h ferr=%b, required 1 1 %h 0 (prev %h)",
                   i, fill_level, source0_valid, source0_data, frame_error, d, prev);
      end
      prev = d;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL stream_summary: bad_cycles=%0d, required 0", bad);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, p);
  endtask

  task automatic test_framing();
    logic p;
    int pulses;
    logic [1:0] seq [5];
    seq[0] = 2'b00; seq[1] = 2'b00; seq[2] = 2'b10; seq[3] = 2'b01; seq[4] = 2'b11;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) step(1'b1, seq[i][1], seq[i][0], 32'hF000 + 32'(i), 2'd0, 1'b0, 1'b1, 1'b0, p);
      else step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, p);
      if (frame_error === 1'b1) pulses++;
      tests_run++;
      if (frame_error !== m_err || (i < 5 && source0_data !== 32'hF000 + 32'(i))) begin
        tests_failed++;
        $display("FAIL framing_cycle_%0d: ferr=%b data=%h, required %b %h", i, frame_error, source0_data,
                 m_err, 32'hF000 + 32'(i));
      end
    end
    tests_run++;
    if (pulses != 2) begin
      tests_failed++;
      $display("FAIL framing_pulses: pulses=%0d, required 2", pulses);
    end
`ifdef ST_PIPE_STATS_EN
    tests_run++;
    if (error_count !== m_errcnt) begin
      tests_failed++;
      $display("FAIL framing_error_count: count=%0d, required %0d", error_count, m_errcnt);
    end
`endif
  endtask

  task automatic test_reset_mid_packet();
    logic p;
    for (int i = 0; i < 3; i++) step(1'b1, (i == 0), 1'b0, 32'hB0 + 32'(i), '0, '0, 1'b0, 1'b0, p);
    tests_run++;
    if (fill_level !== 3'd3) begin
      tests_failed++;
      $display("FAIL midreset_prefill: fill=%0d, required 3", fill_level);
    end
    step(1'b1, 1'b0, 1'b0, 32'hBB, '0, '0, 1'b1, 1'b1, p);
    tests_run++;
    if (fill_level !== 3'd0 || source0_valid !== 1'b0 || sink0_ready !== 1'b0 || frame_error !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: fill=%0d valid=%b ready=%b ferr=%b, required 0 0 0 0",
               fill_level, source0_valid, sink0_ready, frame_error);
    end
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, p);
    step(1'b1, 1'b1, 1'b0, 32'hC0, 2'd1, 1'b1, 1'b0, 1'b0, p);
    tests_run++;
    if (p !== 1'b1 || frame_error !== 1'b0 || source0_valid !== 1'b1 || source0_data !== 32'hC0 ||
        fill_level !== 3'd1) begin
      tests_failed++;
      $display("FAIL midreset_new_sop: ferr=%b valid=%b data=%h fill=%0d, required 0 1 c0 1",
               frame_error, source0_valid, source0_data, fill_level);
    end
    step(1'b1, 1'b0, 1'b1, 32'hC1, 2'd2, 1'b1, 1'b0, 1'b0, p);
  endtask

  task automatic test_wrap();
    logic p;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i % 2 == 0), (i % 2 == 1), 32'hD0 + 32'(i), 2'(i), 1'(i), 1'b1, 1'b0, p);
      tests_run++;
      if (fill_level !== 3'd2 || source0_data !== m_q[0].data || source0_endofpacket !== m_q[0].eop) begin
        tests_failed++;
        $display("FAIL wrap_cycle_%0d: fill=%0d data=%h, required 2 %h", i, fill_level, source0_data, m_q[0].data);
      end
    end
`ifdef ST_PIPE_STATS_EN
    tests_run++;
    if (packet_count !== m_pkt) begin
      tests_failed++;
      $display("FAIL wrap_packet_count: count=%0d, required %0d", packet_count, m_pkt);
    end
`endif
  endtask

  task automatic test_random();
    logic p;
    int bad;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 1'b0, p);
      if (fill_level !== FW'(m_q.size()) || sink0_ready !== m_ready || frame_error !== m_err ||
          source0_valid !== (m_q.size() != 0)) begin
        bad++;
      end else if (m_q.size() != 0) begin
        if (source0_data !== m_q[0].data || source0_startofpacket !== m_q[0].sop ||
            source0_endofpacket !== m_q[0].eop || source0_empty !== m_q[0].empty ||
            source0_channel !== m_q[0].ch) bad++;
      end
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL random_traffic: bad_cycles=%0d, required 0", bad);
    end
`ifdef ST_PIPE_STATS_EN
    tests_run++;
    if (packet_count !== m_pkt || error_count !== m_errcnt) begin
      tests_failed++;
      $display("FAIL random_stats: pkt=%0d err=%0d, required %0d %0d", packet_count, error_count, m_pkt, m_errcnt);
    end
`endif
  endtask

  initial begin
    reset_reset = 1'b1;
    sink0_valid = 1'b0;
    sink0_startofpacket = 1'b0;
    sink0_endofpacket = 1'b0;
    sink0_data = '0;
    sink0_empty = '0;
    sink0_channel = '0;
    source0_ready = 1'b0;
    test_reset();
    test_single_beat();
    test_full();
    test_back_to_back();
    test_framing();
    test_reset_mid_packet();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
